mwrxpktparse: RTL and testbench
===============================

# mwrxpktparse

Downstream consumer of the RX packet buffer in the Ethernet MAC hub. Pops bytes from the buffer's 9-bit (data + EOP) read port and parses the Ethernet/IPv4/UDP header (42 bytes). Discards frames that are not UDP to the configured port. Streams the UDP payload to the DUT-side arbiter as a byte stream with valid/ready/last. Runs entirely in the `dutclk` domain.

## Interface
- `DATAWIDTH`, 8: buffer/stream byte width; only 8 is supported.
- `UDPPORT`, 16'd50000: accepted UDP destination port.
- `PORTMATCH`, 1: 1 = drop frames whose destination port ≠ `UDPPORT`; 0 = accept any port.
- `dutclk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `rxbuffer_rden`  out  1  pop request to the RX buffer.
- `rxbuffer_data`  in  8  popped byte.
- `rxbuffer_datavld`  in  1  `rxbuffer_data` and `rxbuffer_eop` are valid; arrives exactly 1 cycle after `rxbuffer_rden`.
- `rxbuffer_eop`  in  1  last byte of the frame (FCS already stripped).
- `rxbuffer_empty`  in  1  buffer empty.
- `m_tdata`  out  8  payload byte.
- `m_tvalid`  out  1  payload byte valid.
- `m_tready`  in  1  downstream accept.
- `m_tlast`  out  1  last payload byte.
- `m_tuser`  out  1  valid with `m_tlast`; 1 = payload truncated (EOP arrived before the UDP length was exhausted).
- `udp_dstport`  out  16  destination port of the current packet; stable from the first payload beat through `m_tlast`.
- `pkt_ok_count`  out  16  count of forwarded packets; saturating.
- `pkt_drop_count`  out  16  count of dropped frames; saturating.

## Operation
- States:
  - IDLE: wait for buffer not empty.
  - HDR: consume 42 header bytes; byte index `hcnt` runs 0..41.
  - PAYLOAD
  - DROP: pop until `eop` without output.
- Header fields, indexed by `hcnt`:
  - bytes 12–13: ethertype; must be 0x0800.
  - byte 14: IP version/IHL; must be 0x45. IP options are not supported and cause a drop.
  - byte 23: IP protocol; must be 17.
  - bytes 36–37: UDP destination port.
  - bytes 38–39: UDP length.
- Failed check: latch a `bad` flag. At `hcnt`=41, go to PAYLOAD if `bad`=0, else DROP.
- `eop` during HDR: runt frame. Go to IDLE and increment the drop count.
- Payload length: `plen` = UDP length − 8, a 16-bit register.
  - `plen` = 0 or UDP length < 8: drop.
  - Forward `plen` bytes. `m_tlast` goes on byte `plen`.
  - If bytes remain before `eop` (Ethernet padding), enter DROP to flush them. The packet still counts as OK.
  - If `eop` arrives on byte k < `plen`: output byte k with `m_tlast`=1 and `m_tuser`=1. The packet counts as OK.
- Read handshake:
  - `rxbuffer_rden` = `!rxbuffer_empty` && state≠IDLE-pending-reset && credit-available.
  - In HDR and DROP, credit is always available.
  - In PAYLOAD, credit = (skid occupancy + reads in flight) < 2.
  - No reads are issued past the `eop` byte: `rden` drops in the cycle `rxbuffer_datavld`&&`eop` is seen, and the overshoot read is prevented by stopping pops once the final payload/flush byte has been requested.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `rxbuffer_rden`=0, `m_tvalid`=0, `m_tlast`=0, `m_tuser`=0, `udp_dstport`=0, both counters 0, state IDLE, skid buffer empty.
- Latency: a payload byte appears on `m_tdata` 1 cycle after its `rxbuffer_datavld` when the skid buffer is empty.
- Sustained throughput: 1 byte/cycle while `m_tready`=1.
- Backpressure: the skid buffer absorbs the in-flight byte. `m_tvalid`, `m_tdata`, `m_tlast` and `m_tuser` hold stable while `m_tvalid && !m_tready`.
- Back-to-back frames: when EOP is consumed and the buffer is not empty, HDR of the next frame starts with no idle cycle.
- Reset asserted mid-packet: all state clears on the next edge. The partially read frame is not resumed; the buffer owner resets alongside this block.

## Structure
- Shared package `mwrxpkt_pkg`:
  - state enum
  - header offsets: `ETYPE_OFS`=12, `IPVER_OFS`=14, `PROTO_OFS`=23, `DPORT_OFS`=36, `ULEN_OFS`=38
  - `HDRLEN`=42, `ETYPE_IPV4`, `PROTO_UDP`
- One sub-module, `mwskidbuf`: 2-entry valid/ready skid buffer, 10 bits wide (data, last, user).

## Test plan
- Single UDP frame, port 50000, UDP length 12 → 4 payload bytes out; `m_tlast` on the 4th; `pkt_ok_count`=1.
- 60-byte frame with UDP length 10 → 2 bytes out; 16 padding bytes flushed; `rden` idle after EOP.
- Ethertype 0x0806 followed back-to-back by a valid frame → first dropped (`pkt_drop_count`=1); second forwarded intact.
- UDP length 20, frame ends after 5 payload bytes → 5 bytes out; `m_tlast`=1, `m_tuser`=1 on byte 5.
- Valid 64-byte-payload frame with `m_tready` toggled randomly (and held low for 10 cycles) → exact byte sequence with no loss or duplication, at most 2 outstanding reads.
- `reset`=0 asserted mid-payload → next cycle `m_tvalid`=0 and counters=0; a new frame after reset parses correctly.

Source files
------------

// File: rtl/mwrxpktparse_pkg.sv
// Shared types and header layout for the RX packet parser.
package mwrxpkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  // Byte offsets inside the Ethernet/IPv4/UDP header
  localparam logic [5:0] ETYPE_OFS = 6'd12;
  localparam logic [5:0] IPVER_OFS = 6'd14;
  localparam logic [5:0] PROTO_OFS = 6'd23;
  localparam logic [5:0] DPORT_OFS = 6'd36;
  localparam logic [5:0] ULEN_OFS  = 6'd38;
  localparam logic [5:0] HDRLEN    = 6'd42;
  localparam logic [5:0] HDR_LAST  = HDRLEN - 6'd1;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPVER_IHL5 = 8'h45;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;
  localparam logic [15:0] UDP_HDRLEN = 16'd8;

  // Saturating 16-bit increment for the packet counters
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mwrxpktparse_if.sv
// RX buffer read port plus outgoing payload stream.
// Stream handshake: a beat transfers on a clock edge where m_tvalid && m_tready;
// while m_tvalid is high and m_tready low, m_tdata/m_tlast/m_tuser hold stable
// and m_tvalid does not drop. The buffer read port has no ready: rxbuffer_datavld
// follows rxbuffer_rden by exactly one cycle.
interface mwrxpktparse_if #(parameter int DW = 8);
  logic          rxbuffer_rden;
  logic [DW-1:0] rxbuffer_data;
  logic          rxbuffer_datavld;
  logic          rxbuffer_eop;
  logic          rxbuffer_empty;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          m_tuser;

  modport master (
    output rxbuffer_rden,
    input  rxbuffer_data, rxbuffer_datavld, rxbuffer_eop, rxbuffer_empty,
    output m_tdata, m_tvalid, m_tlast, m_tuser,
    input  m_tready
  );

  modport slave (
    input  rxbuffer_rden,
    output rxbuffer_data, rxbuffer_datavld, rxbuffer_eop, rxbuffer_empty,
    input  m_tdata, m_tvalid, m_tlast, m_tuser,
    output m_tready
  );
endinterface

// File: rtl/mwrxpktparse_skidbuf.sv
// Two-entry skid FIFO; entry 0 is the registered output head.
module mwskidbuf #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign pop         = (cnt_q != 2'd0) && out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = e0_q;
  assign count_o     = cnt_q;

  // Next-entry selection for push/pop combinations at each fill level
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (in_valid_i) begin
          e0_d  = in_data_i;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid_i && pop) begin
          e0_d = in_data_i;
        end else if (in_valid_i) begin
          e1_d  = in_data_i;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (in_valid_i) e1_d = in_data_i;
          else            cnt_d = 2'd1;
        end
      end
    endcase
  end

  // Storage registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mwrxpktparse.sv
// Parses Ethernet/IPv4/UDP headers from the RX buffer and streams UDP payload.
module mwrxpktparse
  import mwrxpkt_pkg::*;
#(
  parameter int          DATAWIDTH = 8,
  parameter logic [15:0] UDPPORT   = 16'd50000,
  parameter bit          PORTMATCH = 1'b1
) (
  input  logic        dutclk,
  input  logic        reset,
  mwrxpktparse_if.master bus,
  output logic [15:0] udp_dstport,
  output logic [15:0] pkt_ok_count,
  output logic [15:0] pkt_drop_count,
  output state_t      dbg_state_o
);

  state_t      state_q, state_d;
  logic [5:0]  hcnt_q, hcnt_d;
  logic        bad_q, bad_d;
  logic [15:0] dport_q, dport_d, ulen_q, ulen_d;
  logic [15:0] plen_q, plen_d, pcnt_q, pcnt_d;
  logic [15:0] dst_q, dst_d, ok_q, ok_d, drop_q, drop_d;
  logic        rden_q, rden;
  logic        push, push_last, push_user;
  logic [1:0]  skid_cnt, occ_eff;
  logic        skid_vld;
  logic [DATAWIDTH+1:0] skid_out;

  logic [DATAWIDTH-1:0] byte_in;
  logic eop_seen, hdr_fail, credit, more_pay, out_fire;

  assign byte_in  = bus.rxbuffer_data;
  assign eop_seen = bus.rxbuffer_datavld && bus.rxbuffer_eop;
  assign out_fire = skid_vld && bus.m_tready;
  // Occupancy after this cycle's output pop; lets reads continue at 1 byte/cycle
  assign occ_eff  = skid_cnt - {1'b0, out_fire};
  assign credit   = ({1'b0, occ_eff} + {2'b0, rden_q}) < 3'd2;
  // Reads issued for this payload = bytes received + the one in flight
  assign more_pay = ({1'b0, pcnt_q} + {16'b0, rden_q}) < {1'b0, plen_q};
  assign hdr_fail = (ulen_q <= UDP_HDRLEN) || (PORTMATCH && (dport_q != UDPPORT));

  // Parser next-state, header field capture, read request and skid push
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bad_d     = bad_q;
    dport_d   = dport_q;
    ulen_d    = ulen_q;
    plen_d    = plen_q;
    pcnt_d    = pcnt_q;
    dst_d     = dst_q;
    ok_d      = ok_q;
    drop_d    = drop_q;
    rden      = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    push_user = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hcnt_d = 6'd0;
        bad_d  = 1'b0;
        if (!bus.rxbuffer_empty) state_d = ST_HDR;
      end
      ST_HDR: begin
        rden = !bus.rxbuffer_empty && !eop_seen;
        if (bus.rxbuffer_datavld) begin
          hcnt_d = hcnt_q + 6'd1;
          if (hcnt_q == ETYPE_OFS && byte_in != ETYPE_IPV4[15:8]) bad_d = 1'b1;
          if (hcnt_q == ETYPE_OFS + 6'd1 && byte_in != ETYPE_IPV4[7:0]) bad_d = 1'b1;
          if (hcnt_q == IPVER_OFS && byte_in != IPVER_IHL5) bad_d = 1'b1;
          if (hcnt_q == PROTO_OFS && byte_in != PROTO_UDP) bad_d = 1'b1;
          if (hcnt_q == DPORT_OFS)         dport_d[15:8] = byte_in;
          if (hcnt_q == DPORT_OFS + 6'd1)  dport_d[7:0]  = byte_in;
          if (hcnt_q == ULEN_OFS)          ulen_d[15:8]  = byte_in;
          if (hcnt_q == ULEN_OFS + 6'd1)   ulen_d[7:0]   = byte_in;
          if (bus.rxbuffer_eop) begin
            // Runt: frame ended inside the header
            drop_d  = sat_inc(drop_q);
            hcnt_d  = 6'd0;
            bad_d   = 1'b0;
            state_d = ST_IDLE;
          end else if (hcnt_q == HDR_LAST) begin
            if (bad_q || hdr_fail) begin
              drop_d  = sat_inc(drop_q);
              state_d = ST_DROP;
            end else begin
              plen_d  = ulen_q - UDP_HDRLEN;
              pcnt_d  = 16'd0;
              dst_d   = dport_q;
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        rden = !bus.rxbuffer_empty && credit && more_pay && !eop_seen;
        if (bus.rxbuffer_datavld) begin
          push      = 1'b1;
          pcnt_d    = pcnt_q + 16'd1;
          push_last = bus.rxbuffer_eop || (pcnt_q + 16'd1 == plen_q);
          push_user = bus.rxbuffer_eop && (pcnt_q + 16'd1 != plen_q);
          if (push_last) begin
            ok_d   = sat_inc(ok_q);
            hcnt_d = 6'd0;
            bad_d  = 1'b0;
            if (!bus.rxbuffer_eop)        state_d = ST_DROP;
            else if (bus.rxbuffer_empty)  state_d = ST_IDLE;
            else                          state_d = ST_HDR;
          end
        end
      end
      default: begin
        rden = !bus.rxbuffer_empty && !eop_seen;
        if (eop_seen) begin
          hcnt_d  = 6'd0;
          bad_d   = 1'b0;
          state_d = bus.rxbuffer_empty ? ST_IDLE : ST_HDR;
        end
      end
    endcase
    // No pops while reset is held
    if (!reset) rden = 1'b0;
  end

  // Parser state registers
  always_ff @(posedge dutclk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hcnt_q  <= 6'd0;
      bad_q   <= 1'b0;
      dport_q <= 16'd0;
      ulen_q  <= 16'd0;
      plen_q  <= 16'd0;
      pcnt_q  <= 16'd0;
      dst_q   <= 16'd0;
      ok_q    <= 16'd0;
      drop_q  <= 16'd0;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bad_q   <= bad_d;
      dport_q <= dport_d;
      ulen_q  <= ulen_d;
      plen_q  <= plen_d;
      pcnt_q  <= pcnt_d;
      dst_q   <= dst_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
      rden_q  <= rden;
    end
  end

  mwskidbuf #(.W(DATAWIDTH + 2)) u_skid (
    .clk_i       (dutclk),
    .rst_ni      (reset),
    .in_valid_i  (push),
    .in_data_i   ({push_last, push_user, byte_in}),
    .out_valid_o (skid_vld),
    .out_ready_i (bus.m_tready),
    .out_data_o  (skid_out),
    .count_o     (skid_cnt)
  );

  assign bus.rxbuffer_rden = rden;
  assign bus.m_tvalid      = skid_vld;
  assign bus.m_tdata       = skid_out[DATAWIDTH-1:0];
  assign bus.m_tuser       = skid_out[DATAWIDTH];
  assign bus.m_tlast       = skid_out[DATAWIDTH+1];
  assign udp_dstport       = dst_q;
  assign pkt_ok_count      = ok_q;
  assign pkt_drop_count    = drop_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mwrxpktparse.sv
// Bench for mwrxpktparse: RX buffer model, payload scoreboard, directed frames.
module tb_mwrxpktparse;
  import mwrxpkt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mwrxpktparse_if #(.DW(8)) ifc ();
  logic [15:0] udp_dstport, ok_cnt, drop_cnt;
  state_t      dbg_state;

  mwrxpktparse #(.DATAWIDTH(8), .UDPPORT(16'd50000), .PORTMATCH(1'b1)) dut (
    .dutclk        (clk),
    .reset         (rst_n),
    .bus           (ifc),
    .udp_dstport   (udp_dstport),
    .pkt_ok_count  (ok_cnt),
    .pkt_drop_count(drop_cnt),
    .dbg_state_o   (dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- RX buffer model ----------------
  logic [8:0] rxq[$];   // {eop, data}
  initial begin
    ifc.rxbuffer_data    = 8'h00;
    ifc.rxbuffer_datavld = 1'b0;
    ifc.rxbuffer_eop     = 1'b0;
    ifc.rxbuffer_empty   = 1'b1;
  end

  always @(posedge clk) begin
    logic [8:0] e;
    if (ifc.rxbuffer_datavld && ifc.rxbuffer_eop)
      chk("rden_after_eop", 32'(ifc.rxbuffer_rden), 32'd0);
    if (ifc.rxbuffer_rden) begin
      chk("rd_nonempty", 32'(rxq.size() != 0), 32'd1);
      e = (rxq.size() != 0) ? rxq.pop_front() : 9'h000;
      ifc.rxbuffer_data    <= e[7:0];
      ifc.rxbuffer_eop     <= e[8];
      ifc.rxbuffer_datavld <= 1'b1;
    end else begin
      ifc.rxbuffer_datavld <= 1'b0;
      ifc.rxbuffer_eop     <= 1'b0;
    end
    ifc.rxbuffer_empty <= (rxq.size() == 0);
  end

  // ---------------- downstream ready driver ----------------
  bit bp_en = 0;
  int hold_lo = 0;
  initial begin
    ifc.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_lo > 0) begin
        ifc.m_tready = 1'b0;
        hold_lo--;
      end else if (bp_en) begin
        ifc.m_tready = 1'($urandom_range(0, 1));
      end else begin
        ifc.m_tready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];  // {last, user, data}
  bit mon_en = 0;
  logic hold_pend = 1'b0;
  logic [10:0] held = '0;
  int n_beats = 0;

  always @(negedge clk) begin
    logic [10:0] expv;
    if (mon_en && rst_n) begin
      if (hold_pend)
        chk("hold_stable", 32'({ifc.m_tvalid, ifc.m_tlast, ifc.m_tuser, ifc.m_tdata}), 32'(held));
      if (ifc.m_tvalid && ifc.m_tready) begin
        expv = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 11'h400;
        chk("beat", 32'({1'b0, ifc.m_tlast, ifc.m_tuser, ifc.m_tdata}), 32'(expv));
        chk("udp_dstport", 32'(udp_dstport), 32'd50000);
        n_beats <= n_beats + 1;
      end
      hold_pend <= ifc.m_tvalid && !ifc.m_tready;
      held      <= {ifc.m_tvalid, ifc.m_tlast, ifc.m_tuser, ifc.m_tdata};
    end else begin
      hold_pend <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [15:0] etype, input logic [7:0] verihl,
                            input logic [7:0] proto, input logic [15:0] dport,
                            input logic [15:0] ulen, input int nbody, input logic [7:0] seed);
    logic [7:0] b;
    for (int i = 0; i < 42; i++) begin
      b = 8'(i * 3 + 1);
      case (i)
        12: b = etype[15:8];
        13: b = etype[7:0];
        14: b = verihl;
        23: b = proto;
        36: b = dport[15:8];
        37: b = dport[7:0];
        38: b = ulen[15:8];
        39: b = ulen[7:0];
        default: ;
      endcase
      rxq.push_back({(i == 41) && (nbody == 0), b});
    end
    for (int i = 0; i < nbody; i++)
      rxq.push_back({i == nbody - 1, seed + 8'(i)});
  endtask

  task automatic exp_run(input logic [7:0] seed, input int n, input logic user_last);
    for (int i = 0; i < n; i++)
      exp_q.push_back({i == n - 1, (i == n - 1) && user_last, seed + 8'(i)});
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || rxq.size() != 0 || !ifc.rxbuffer_empty) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(name, 32'(c < 3000), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", 32'(ifc.rxbuffer_rden), 32'd0);
    chk("rst_tvalid", 32'(ifc.m_tvalid), 32'd0);
    chk("rst_tlast_tuser", 32'({ifc.m_tlast, ifc.m_tuser}), 32'd0);
    chk("rst_dport", 32'(udp_dstport), 32'd0);
    chk("rst_counts", 32'({ok_cnt, drop_cnt}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    mon_en = 1;

    // T1: UDP length 12 -> 4 payload bytes
    exp_q.push_back({1'b0, 1'b0, 8'hA0});
    exp_q.push_back({1'b0, 1'b0, 8'hA1});
    exp_q.push_back({1'b0, 1'b0, 8'hA2});
    exp_q.push_back({1'b1, 1'b0, 8'hA3});
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd12, 4, 8'hA0);
    wait_drain("t1_drain");
    chk("t1_ok", 32'(ok_cnt), 32'd1);
    chk("t1_drop", 32'(drop_cnt), 32'd0);

    // T2: 60-byte frame, UDP length 10 -> 2 bytes, 16 pad bytes flushed
    exp_run(8'hB0, 2, 1'b0);
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd10, 18, 8'hB0);
    wait_drain("t2_drain");
    chk("t2_ok", 32'(ok_cnt), 32'd2);
    chk("t2_idle_rden", 32'(ifc.rxbuffer_rden), 32'd0);
    chk("t2_state", 32'(dbg_state), 32'(ST_IDLE));

    // T3: ARP frame then back-to-back valid frame (UDP length 14 -> 6 bytes)
    exp_run(8'hD0, 6, 1'b0);
    push_frame(16'h0806, 8'h45, 8'd17, 16'd50000, 16'd12, 4, 8'hC0);
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd14, 6, 8'hD0);
    wait_drain("t3_drain");
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    chk("t3_ok", 32'(ok_cnt), 32'd3);

    // T4: UDP length 20 but frame ends after 5 payload bytes -> truncated
    exp_run(8'hE0, 5, 1'b1);
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd20, 5, 8'hE0);
    wait_drain("t4_drain");
    chk("t4_ok", 32'(ok_cnt), 32'd4);

    // T5: 64-byte payload under random backpressure plus a 10-cycle stall
    exp_run(8'h10, 64, 1'b0);
    bp_en = 1;
    start = n_beats;
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd72, 64, 8'h10);
    c = 0;
    while (n_beats < start + 8 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    chk("t5_progress", 32'(c < 1000), 32'd1);
    hold_lo = 10;
    wait_drain("t5_drain");
    bp_en = 0;
    chk("t5_ok", 32'(ok_cnt), 32'd5);
    chk("t5_drop", 32'(drop_cnt), 32'd1);

    // T6: port mismatch, non-UDP protocol, zero-length payload, IP options -> all dropped
    push_frame(16'h0800, 8'h45, 8'd17, 16'd1234, 16'd18, 10, 8'h20);
    push_frame(16'h0800, 8'h45, 8'd6, 16'd50000, 16'd18, 10, 8'h30);
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd8, 4, 8'h40);
    push_frame(16'h0800, 8'h46, 8'd17, 16'd50000, 16'd12, 8, 8'h50);
    wait_drain("t6_drain");
    chk("t6_drop", 32'(drop_cnt), 32'd5);
    chk("t6_ok", 32'(ok_cnt), 32'd5);

    // T7: reset mid-payload, then a fresh frame
    exp_run(8'h60, 64, 1'b0);
    start = n_beats;
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd72, 64, 8'h60);
    c = 0;
    while (n_beats < start + 5 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    chk("t7_progress", 32'(c < 1000), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 0;
    rst_n = 1'b0;
    rxq.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t7_tvalid", 32'(ifc.m_tvalid), 32'd0);
    chk("t7_counts", 32'({ok_cnt, drop_cnt}), 32'd0);
    chk("t7_dport", 32'(udp_dstport), 32'd0);
    chk("t7_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;
    exp_run(8'h70, 3, 1'b0);
    push_frame(16'h0800, 8'h45, 8'd17, 16'd50000, 16'd11, 3, 8'h70);
    wait_drain("t7_drain");
    chk("t7_ok", 32'(ok_cnt), 32'd1);
    chk("t7_drop", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
